// File: rtl/pwm_demodulator.sv
// PWM receive-side demodulator: measures high time and rising-to-rising period of an
// asynchronous PWM input and recovers the offset-removed sample word once per period.
`timescale 1ns/1ps

module pwm_demodulator #(
  parameter int OUTPUT_WIDTH  = 12,
  parameter int COUNTER_WIDTH = 10,
  parameter int OFFSET        = 512,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pwm_in,
  output logic [OUTPUT_WIDTH-1:0] data_out,
  output logic [COUNTER_WIDTH:0]  high_cycles,
  output logic [COUNTER_WIDTH:0]  period_cycles,
  output logic                    sample_valid,
  output logic                    stuck_high,
  output logic                    stuck_low,
  output logic                    locked
);

  localparam int CNT_W = COUNTER_WIDTH + 1;
  localparam logic [CNT_W-1:0] LIMIT    = {1'b1, {COUNTER_WIDTH{1'b0}}};
  localparam logic [CNT_W-1:0] LIMIT_M1 = {1'b0, {COUNTER_WIDTH{1'b1}}};
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  localparam logic [OUTPUT_WIDTH-1:0] DATA_BIAS       = OUTPUT_WIDTH'(OFFSET + 1);
  localparam logic [OUTPUT_WIDTH-1:0] STUCK_HIGH_DATA = OUTPUT_WIDTH'((2 ** COUNTER_WIDTH) - 1 - OFFSET);
  localparam logic [OUTPUT_WIDTH-1:0] STUCK_LOW_DATA  = OUTPUT_WIDTH'(0 - OFFSET);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic                   s;
  logic                   rise;
  logic                   fall;

  state_e                  state_q;
  logic [CNT_W-1:0]        hcnt_q;
  logic [CNT_W-1:0]        pcnt_q;
  logic [CNT_W-1:0]        hcnt_inc;
  logic [CNT_W-1:0]        pcnt_inc;
  logic [OUTPUT_WIDTH-1:0] normal_data;

  logic [OUTPUT_WIDTH-1:0] data_q;
  logic [CNT_W-1:0]        high_q;
  logic [CNT_W-1:0]        period_q;
  logic                    valid_q;
  logic                    stuck_high_q;
  logic                    stuck_low_q;
  logic                    locked_q;

  assign s           = sync_q[SYNC_STAGES-1];
  assign rise        = s & ~s_d_q;
  assign fall        = ~s & s_d_q;
  assign hcnt_inc    = hcnt_q + ONE;
  assign pcnt_inc    = pcnt_q + ONE;
  assign normal_data = OUTPUT_WIDTH'(hcnt_q) - DATA_BIAS;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_d_q  <= s;
    end
  end

  // NOTE: every branch below reads pre-edge register values because all state uses
  // non-blocking assignment; the normal sample relies on that to report the old hcnt/pcnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hcnt_q       <= '0;
      pcnt_q       <= '0;
      data_q       <= '0;
      high_q       <= '0;
      period_q     <= '0;
      valid_q      <= 1'b0;
      stuck_high_q <= 1'b0;
      stuck_low_q  <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (rise) begin
            hcnt_q  <= ONE;
            pcnt_q  <= ONE;
            state_q <= ST_HIGH;
          end else if (pcnt_q == LIMIT_M1) begin
            // The current low cycle is the LIMIT-th one, so the timeout fires now.
            valid_q      <= 1'b1;
            data_q       <= STUCK_LOW_DATA;
            high_q       <= '0;
            period_q     <= LIMIT;
            stuck_high_q <= 1'b0;
            stuck_low_q  <= 1'b1;
            locked_q     <= 1'b0;
            pcnt_q       <= '0;
          end else begin
            pcnt_q <= pcnt_inc;
          end
        end

        ST_HIGH: begin
          if (fall) begin
            pcnt_q  <= pcnt_inc;
            state_q <= ST_LOW;
          end else if (hcnt_q == LIMIT_M1) begin
            valid_q      <= 1'b1;
            data_q       <= STUCK_HIGH_DATA;
            high_q       <= LIMIT;
            period_q     <= LIMIT;
            stuck_high_q <= 1'b1;
            stuck_low_q  <= 1'b0;
            locked_q     <= 1'b0;
            hcnt_q       <= '0;
            pcnt_q       <= '0;
          end else begin
            hcnt_q <= hcnt_inc;
            pcnt_q <= pcnt_inc;
          end
        end

        ST_LOW: begin
          if (rise) begin
            valid_q      <= 1'b1;
            data_q       <= normal_data;
            high_q       <= hcnt_q;
            period_q     <= pcnt_q;
            stuck_high_q <= 1'b0;
            stuck_low_q  <= 1'b0;
            locked_q     <= 1'b1;
            hcnt_q       <= ONE;
            pcnt_q       <= ONE;
            state_q      <= ST_HIGH;
          end else if (pcnt_q == LIMIT) begin
            // A full-length period closes on a rise seen with pcnt == LIMIT, so the
            // timeout only fires once that rise has failed to appear.
            valid_q      <= 1'b1;
            data_q       <= STUCK_LOW_DATA;
            high_q       <= '0;
            period_q     <= LIMIT;
            stuck_high_q <= 1'b0;
            stuck_low_q  <= 1'b1;
            locked_q     <= 1'b0;
            hcnt_q       <= '0;
            pcnt_q       <= '0;
            state_q      <= ST_IDLE;
          end else begin
            pcnt_q <= pcnt_inc;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data_out      = data_q;
  assign high_cycles   = high_q;
  assign period_cycles = period_q;
  assign sample_valid  = valid_q;
  assign stuck_high    = stuck_high_q;
  assign stuck_low     = stuck_low_q;
  assign locked        = locked_q;

endmodule

// File: doc/pwm_demodulator.md
Name: pwm_demodulator

Overview:
- Receive-side counterpart of the PWM DAC output stage: measures an incoming PWM waveform and recovers the sample word that produced it.
- Used for loopback verification of the PWM output path. Also usable as a low-rate duty-cycle ADC front end.
- Per period it reports high time, period length and the offset-removed sample, with a one-cycle valid strobe. Stuck-level inputs are detected by timeout.

Parameters:
- OUTPUT_WIDTH, 12, width of recovered sample data_out.
- COUNTER_WIDTH, 10, nominal PWM period is 2^COUNTER_WIDTH cycles; also sets the timeout limit.
- OFFSET, 512, offset removed from the measured duty value.
- SYNC_STAGES, 2, synchronizer flops on pwm_in (min 2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- pwm_in  input  1  PWM waveform, asynchronous to clk.
- data_out  output  OUTPUT_WIDTH  recovered sample, two's-complement modulo 2^OUTPUT_WIDTH.
- high_cycles  output  COUNTER_WIDTH+1  measured high time of last period, in clk cycles.
- period_cycles  output  COUNTER_WIDTH+1  measured rising-to-rising period, in clk cycles.
- sample_valid  output  1  one-cycle strobe; outputs updated this cycle.
- stuck_high  output  1  last sample produced by high-level timeout.
- stuck_low  output  1  last sample produced by low-level timeout.
- locked  output  1  at least one edge-bounded period measured since reset or last timeout.

Behaviour:
- Reset: all outputs 0, all synchronizer and edge flops 0, counters 0, state IDLE. Reset has priority over all events.
- Synchronizer: pwm_in passes through SYNC_STAGES flops to give level s.
- Edge detection: a one-flop delay s_d is compared with s. rise = s & ~s_d; fall = ~s & s_d. The "detect cycle" is the cycle the edge term is 1.
- Counters: hcnt and pcnt, both COUNTER_WIDTH+1 bits. LIMIT = 2^COUNTER_WIDTH.
- State IDLE: wait for rise.
  - On rise: hcnt=1, pcnt=1, go to HIGH.
  - pcnt counts cycles with s low. When pcnt reaches LIMIT, emit stuck-low sample and restart pcnt at 0.
- State HIGH: hcnt++ and pcnt++ each cycle.
  - On fall: go to LOW.
  - When hcnt reaches LIMIT with no fall, emit stuck-high sample. Then hcnt=0, pcnt=0, locked=0, stay in HIGH.
- State LOW: pcnt++ each cycle.
  - On rise: emit normal sample using the pre-edge hcnt/pcnt, then hcnt=1, pcnt=1, go to HIGH.
  - When pcnt reaches LIMIT with no rise, emit stuck-low sample, locked=0, go to IDLE.
- Normal sample:
  - high_cycles = hcnt; period_cycles = pcnt.
  - data_out = (hcnt - 1) - OFFSET, computed at OUTPUT_WIDTH bits, wrap allowed.
  - stuck flags cleared; locked=1.
- Stuck-high sample:
  - high_cycles = period_cycles = LIMIT.
  - data_out = (LIMIT - 1) - OFFSET.
  - stuck_high=1, stuck_low=0.
- Stuck-low sample:
  - high_cycles = 0; period_cycles = LIMIT.
  - data_out = 0 - OFFSET.
  - stuck_low=1, stuck_high=0.
- Latency: sample_valid rises exactly one clk after the detect cycle of the closing rise, or after the cycle the limit is reached.
- Output hold: outputs hold between strobes. sample_valid is never high two consecutive cycles.
- Glitches: no filtering. A 1-cycle high pulse gives a sample with hcnt=1.
- Simultaneous events: a rise in the same cycle pcnt reaches LIMIT is treated as a normal sample; the edge wins.
- Reset mid-period: the partial measurement is discarded and no strobe is emitted.

Test Plan:
- Matched transmitter, period 1024, high 513 cycles (source word 0) -> first strobe after second rise; data_out=0, high_cycles=513, period_cycles=1024, locked=1.
- Source word 100 (high 613) -> data_out=100. Source word 12'hF00 (high 257) -> data_out=12'hF00, period_cycles=1024.
- pwm_in held high after a rise -> strobe after 1024 high cycles; data_out=511, high_cycles=1024, stuck_high=1, locked=0. Repeats every 1024 cycles.
- pwm_in held low from reset -> strobe every 1024 cycles; data_out=12'hE00, high_cycles=0, stuck_low=1. A subsequent valid waveform clears stuck_low on its first normal sample.
- Assert rst for 1 cycle mid-HIGH -> all outputs 0 next cycle and no strobe for that period. The next measurement requires a fresh rise plus one full period.
- Synthetic rise coinciding with pcnt reaching 1024 -> one normal sample with period_cycles=1024 and stuck_low=0. One cycle high glitch -> sample with high_cycles=1, data_out=12'hE00.
